hls_run_sequencer: RTL

HLS_RUN_SEQUENCER -- requirements
Module: hls_run_sequencer

---
 rtl/hls_run_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hls_run_sequencer.sv
// Batch sequencer for an HLS accelerator: resets, starts and times each run, reporting per-run latency.
// Optional watchdog enabled by defining HLS_RUN_SEQ_TIMEOUT_EN.
module hls_run_sequencer #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned RUNS_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [RUNS_W-1:0] n_runs,
  output logic              acc_reset,
  output logic              acc_start,
  input  logic              acc_done,
  output logic              busy,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_cycles,
  output logic              res_timeout,
  output logic [RUNS_W-1:0] res_index,
  output logic              batch_done
);

  typedef enum logic [2:0] {
    IDLE, RST0, RST1, START, WAIT, REPORT, FIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [RUNS_W-1:0] runs_q;

`ifdef HLS_RUN_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
`else
  assign res_timeout = 1'b0;
`endif

  // Saturating increment; also used as the latched latency so the done cycle is counted.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != '1) cnt_inc = cnt + CNT_W'(1);
  end

  // Outputs are registered: each transition sets the values the destination state presents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      runs_q     <= '0;
      res_cycles <= '0;
      res_index  <= '0;
      res_valid  <= 1'b0;
      batch_done <= 1'b0;
      acc_start  <= 1'b0;
      acc_reset  <= 1'b1;
      busy       <= 1'b0;
`ifdef HLS_RUN_SEQ_TIMEOUT_EN
      res_timeout <= 1'b0;
`endif
    end else begin
      acc_start  <= 1'b0;
      res_valid  <= 1'b0;
      batch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            runs_q    <= n_runs;
            res_index <= '0;
            busy      <= 1'b1;
            if (n_runs == '0) begin
              state      <= FIN;
              batch_done <= 1'b1;
            end else begin
              state     <= RST0;
              acc_reset <= 1'b0;
            end
          end
        end
        RST0: state <= RST1;
        RST1: begin
          state     <= START;
          acc_reset <= 1'b1;
          acc_start <= 1'b1;
          cnt       <= CNT_W'(1);
        end
        START: begin
          if (acc_done) begin
            state      <= REPORT;
            res_valid  <= 1'b1;
            res_cycles <= CNT_W'(1);
`ifdef HLS_RUN_SEQ_TIMEOUT_EN
            res_timeout <= 1'b0;
`endif
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (acc_done) begin
            state      <= REPORT;
            res_valid  <= 1'b1;
            res_cycles <= cnt_inc;
`ifdef HLS_RUN_SEQ_TIMEOUT_EN
            res_timeout <= 1'b0;
          end else if (cnt == TIMEOUT_LIM) begin
            state       <= REPORT;
            res_valid   <= 1'b1;
            res_cycles  <= TIMEOUT_LIM;
            res_timeout <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
        REPORT: begin
          if (res_index != runs_q - RUNS_W'(1)) begin
            state     <= RST0;
            res_index <= res_index + RUNS_W'(1);
            acc_reset <= 1'b0;
          end else begin
            state      <= FIN;
            batch_done <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          acc_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
